// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage load/store controller for an SRAM-like data bus
// (req / addr_ok / data_ok handshake) with byte strobes and lane-replicated store data.
// It returns aligned, sign- or zero-extended load data to write-back.
// Build option MEM_ADDR_CHECK_EN: when defined, a misaligned half/word access skips the
// bus and raises an address error (AdEL=4 / AdES=5). When undefined, the low address bits
// are masked to the access size, so every request reaches the bus.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_write,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_flush,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_exc,
  output logic [4:0]        out_exc_code,
  output logic [ADDR_W-1:0] out_badvaddr,
  output logic              d_req,
  output logic              d_wr,
  output logic [1:0]        d_size,
  output logic [ADDR_W-1:0] d_addr,
  output logic [3:0]        d_wstrb,
  output logic [DATA_W-1:0] d_wdata,
  input  logic              d_addr_ok,
  input  logic              d_data_ok,
  input  logic [DATA_W-1:0] d_rdata
);

  typedef enum logic [2:0] {IDLE = 3'd0, ADDR = 3'd1, DATA = 3'd2, RESP = 3'd3, DRAIN = 3'd4} state_t;

  state_t            state_reg, state_next;
  logic              wr_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              accept;
  logic              misaligned;
  logic              resp_bus;
  logic [ADDR_W-1:0] addr_cap;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;
  logic [3:0]        strb;
  logic [DATA_W-1:0] wdata_rep;

  assign accept = (state_reg == IDLE) && in_valid && !in_flush;

`ifdef MEM_ADDR_CHECK_EN
  assign misaligned = ((in_size == 2'd1) && in_addr[0]) || (in_size[1] && (in_addr[1:0] != 2'b00));
  assign addr_cap   = in_addr;
`else
  assign misaligned = 1'b0;

  // Force natural alignment so the bus never sees a misaligned access
  always_comb begin
    addr_cap = in_addr;
    if (in_size == 2'd1) begin
      addr_cap[0] = 1'b0;
    end else if (in_size[1]) begin
      addr_cap[1:0] = 2'b00;
    end
  end
`endif

  // Next-state logic. A flush arriving together with the bus completion discards the data.
  always_comb begin
    state_next = state_reg;
    resp_bus   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = misaligned ? RESP : ADDR;
      end
      ADDR: begin
        if (d_addr_ok) begin
          if (d_data_ok) begin
            if (in_flush) begin
              state_next = IDLE;
            end else begin
              state_next = RESP;
              resp_bus   = 1'b1;
            end
          end else begin
            state_next = in_flush ? DRAIN : DATA;
          end
        end else if (in_flush) begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (d_data_ok) begin
          if (in_flush) begin
            state_next = IDLE;
          end else begin
            state_next = RESP;
            resp_bus   = 1'b1;
          end
        end else if (in_flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (d_data_ok) state_next = IDLE;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane selection, extension, strobes and store-data replication from the captured request
  always_comb begin
    shifted = d_rdata >> {addr_reg[1:0], 3'b000};
    case (size_reg)
      2'd0: begin
        load_ext  = signed_reg ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
        strb      = 4'b0001 << addr_reg[1:0];
        wdata_rep = {4{wdata_reg[7:0]}};
      end
      2'd1: begin
        load_ext  = signed_reg ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
        strb      = 4'b0011 << addr_reg[1:0];
        wdata_rep = {2{wdata_reg[15:0]}};
      end
      default: begin
        load_ext  = shifted;
        strb      = 4'b1111;
        wdata_rep = wdata_reg;
      end
    endcase
  end

  // State register, request capture and result latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      wr_reg     <= 1'b0;
      size_reg   <= 2'd0;
      signed_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        wr_reg     <= in_write;
        size_reg   <= in_size;
        signed_reg <= in_signed;
        addr_reg   <= addr_cap;
        wdata_reg  <= in_wdata;
      end
      if (resp_bus) begin
        rdata_reg <= wr_reg ? '0 : load_ext;
      end else if (accept && misaligned) begin
        rdata_reg <= '0;
      end
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  logic              exc_reg;
  logic [4:0]        exc_code_reg;
  logic [ADDR_W-1:0] badvaddr_reg;

  // Exception fields are written only when a response is produced, so they hold between responses
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_reg      <= 1'b0;
      exc_code_reg <= 5'd0;
      badvaddr_reg <= '0;
    end else if (accept && misaligned) begin
      exc_reg      <= 1'b1;
      exc_code_reg <= in_write ? 5'd5 : 5'd4;
      badvaddr_reg <= in_addr;
    end else if (resp_bus) begin
      exc_reg      <= 1'b0;
      exc_code_reg <= 5'd0;
      badvaddr_reg <= '0;
    end
  end

  assign out_exc      = exc_reg;
  assign out_exc_code = exc_code_reg;
  assign out_badvaddr = badvaddr_reg;
`else
  assign out_exc      = 1'b0;
  assign out_exc_code = 5'd0;
  assign out_badvaddr = '0;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == RESP) && !in_flush;
  assign out_rdata = rdata_reg;

  // Bus fields are driven only while requesting, so they stay quiet otherwise
  assign d_req   = (state_reg == ADDR);
  assign d_wr    = d_req && wr_reg;
  assign d_size  = d_req ? (size_reg[1] ? 2'd2 : size_reg) : 2'd0;
  assign d_addr  = d_req ? addr_reg : '0;
  assign d_wstrb = d_req ? strb : 4'd0;
  assign d_wdata = d_req ? wdata_rep : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: table vectors, randomized transactions checked against a
// behavioural reference model, and hand-written flush/reset sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_write, in_signed, in_flush;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic        busy, out_valid, out_exc;
  logic [31:0] out_rdata, out_badvaddr;
  logic [4:0]  out_exc_code;
  logic        d_req, d_wr, d_addr_ok, d_data_ok;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rdata;

`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write), .in_size(in_size),
    .in_signed(in_signed), .in_addr(in_addr), .in_wdata(in_wdata), .in_flush(in_flush),
    .busy(busy), .out_valid(out_valid), .out_rdata(out_rdata), .out_exc(out_exc),
    .out_exc_code(out_exc_code), .out_badvaddr(out_badvaddr),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wstrb(d_wstrb),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aw;
    int          dw;
    logic [31:0] e_addr;
    logic [1:0]  e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_exc;
    logic [4:0]  e_code;
    int          lat;
  } txn_t;

  function automatic void chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", what, act, exp);
    end
  endfunction

  // Reference: derive the expected bus view and result from the access rules with plain arithmetic
  function automatic txn_t model(input txn_t t);
    txn_t        r;
    int          nb;
    int          lane;
    logic [31:0] eff;
    longint      v;
    longint      mask;
    r = t;
    nb = (t.sz == 2'd0) ? 1 : ((t.sz == 2'd1) ? 2 : 4);
    r.e_exc = CHK && ((t.addr % 32'(nb)) != 32'd0);
    eff = CHK ? t.addr : (t.addr - (t.addr % 32'(nb)));
    lane = int'(eff % 32'd4);
    r.e_addr = eff;
    r.e_size = (nb == 1) ? 2'd0 : ((nb == 2) ? 2'd1 : 2'd2);
    r.e_strb = 4'(((1 << nb) - 1) << lane);
    for (int i = 0; i < 4; i++) r.e_wdata[8*i +: 8] = 8'(t.wdata >> (8 * (i % nb)));
    if (t.wr || r.e_exc) begin
      r.e_rdata = 32'd0;
    end else begin
      v = longint'({32'd0, t.rdata} >> (8 * lane));
      mask = (longint'(1) << (8 * nb)) - 1;
      v = v & mask;
      if (t.sg && (((v >> (8 * nb - 1)) & 1) != 0)) v = v | ~mask;
      r.e_rdata = 32'(v);
    end
    r.e_code = r.e_exc ? (t.wr ? 5'd5 : 5'd4) : 5'd0;
    r.lat = r.e_exc ? 1 : (t.aw + t.dw + 2);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, act as the bus slave with the given wait states, check everything
  task automatic do_txn(input txn_t t, input int idx);
    int cyc_n = 0;
    int wa = 0;
    int wd = 0;
    bit addr_done = 0;
    bit data_done = 0;
    bit got = 0;
    bit seen_req = 0;
    in_valid = 1'b1; in_write = t.wr; in_size = t.sz; in_signed = t.sg;
    in_addr = t.addr; in_wdata = t.wdata; in_flush = 1'b0;
    #1;
    chk("accept_ready", 32'(in_ready), 32'd1);
    while (!got && cyc_n < 64) begin
      step();
      cyc_n++;
      in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
      in_size = 2'($urandom); in_write = 1'($urandom); in_signed = 1'($urandom);
      d_addr_ok = 1'b0; d_data_ok = 1'b0; d_rdata = $urandom;
      if (d_req) begin
        if (addr_done) begin
          chk("req_after_addr_ok", 32'(d_req), 32'd0);
        end else begin
          if (!seen_req) begin
            seen_req = 1'b1;
            chk("d_addr", d_addr, t.e_addr);
            chk("d_wr", 32'(d_wr), 32'(t.wr));
            chk("d_size", 32'(d_size), 32'(t.e_size));
            if (t.wr) begin
              chk("d_wstrb", 32'(d_wstrb), 32'(t.e_strb));
              chk("d_wdata", d_wdata, t.e_wdata);
            end
          end
          if (wa == t.aw) begin
            d_addr_ok = 1'b1;
            addr_done = 1'b1;
            if (t.dw == 0) begin
              d_data_ok = 1'b1; d_rdata = t.rdata; data_done = 1'b1;
            end
          end else begin
            wa++;
          end
        end
      end else if (addr_done && !data_done) begin
        wd++;
        if (wd == t.dw) begin
          d_data_ok = 1'b1; d_rdata = t.rdata; data_done = 1'b1;
        end
      end
      #1;
      if (out_valid) got = 1'b1;
      else chk("busy_wait", 32'({in_ready, busy}), 32'b01);
    end
    chk("completed", 32'(got), 32'd1);
    if (got) begin
      chk("latency", 32'(cyc_n), 32'(t.lat));
      chk("out_exc", 32'(out_exc), 32'(t.e_exc));
      if (t.e_exc) begin
        chk("exc_code", 32'(out_exc_code), 32'(t.e_code));
        chk("badvaddr", out_badvaddr, t.addr);
        chk("no_bus_on_exc", 32'(seen_req), 32'd0);
      end else begin
        chk("out_rdata", out_rdata, t.e_rdata);
      end
      last_rdata = t.e_rdata;
    end
    step();
    d_addr_ok = 1'b0; d_data_ok = 1'b0;
    #1;
    chk("pulse_end", 32'({out_valid, in_ready}), 32'b01);
    $display("txn %0d: wr=%0d size=%0d addr=%08h rdata=%08h exc=%0d code=%0d lat=%0d",
             idx, t.wr, t.sz, t.addr, out_rdata, out_exc, out_exc_code, cyc_n);
  endtask

  txn_t tbl[10];
  txn_t rt;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_write = 1'b0; in_size = 2'd0; in_signed = 1'b0;
    in_addr = 32'd0; in_wdata = 32'd0; in_flush = 1'b0;
    d_addr_ok = 1'b0; d_data_ok = 1'b0; d_rdata = 32'd0;
    last_rdata = 32'd0;

    //              wr    sz    sg    addr        wdata         rdata        aw dw  e_addr      e_sz  e_strb   e_wdata       e_rdata      exc   code lat
    tbl[0] = '{1'b0, 2'd0, 1'b1, 32'h1003, 32'h0,        32'h80FF1234, 0, 0, 32'h1003, 2'd0, 4'h0,    32'h0,        32'hFFFFFF80, 1'b0, 5'd0, 2};
    tbl[1] = '{1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 32'h0,        0, 0, 32'h2002, 2'd1, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0, 5'd0, 2};
    tbl[2] = '{1'b0, 2'd2, 1'b0, 32'h3000, 32'h0,        32'hDEADBEEF, 2, 3, 32'h3000, 2'd2, 4'h0,    32'h0,        32'hDEADBEEF, 1'b0, 5'd0, 7};
    tbl[3] = '{1'b0, 2'd1, 1'b0, 32'h0006, 32'h0,        32'h80017FFF, 1, 0, 32'h0006, 2'd1, 4'h0,    32'h0,        32'h00008001, 1'b0, 5'd0, 3};
    tbl[4] = '{1'b0, 2'd0, 1'b0, 32'h0001, 32'h0,        32'h0000F100, 0, 1, 32'h0001, 2'd0, 4'h0,    32'h0,        32'h000000F1, 1'b0, 5'd0, 3};
    tbl[5] = '{1'b1, 2'd0, 1'b0, 32'h0005, 32'h12345678, 32'h0,        0, 0, 32'h0005, 2'd0, 4'b0010, 32'h78787878, 32'h0,        1'b0, 5'd0, 2};
    tbl[6] = '{1'b1, 2'd3, 1'b0, 32'h0008, 32'hCAFEF00D, 32'h0,        1, 2, 32'h0008, 2'd2, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 5'd0, 5};
    tbl[7] = '{1'b0, 2'd1, 1'b1, 32'h000A, 32'h0,        32'h9ABC0000, 0, 0, 32'h000A, 2'd1, 4'h0,    32'h0,        32'hFFFF9ABC, 1'b0, 5'd0, 2};
`ifdef MEM_ADDR_CHECK_EN
    tbl[8] = '{1'b1, 2'd2, 1'b0, 32'h4001, 32'h11223344, 32'h0,        0, 0, 32'h0,    2'd0, 4'h0,    32'h0,        32'h0,        1'b1, 5'd5, 1};
    tbl[9] = '{1'b0, 2'd1, 1'b1, 32'h5003, 32'h0,        32'hAABBCCDD, 0, 0, 32'h0,    2'd0, 4'h0,    32'h0,        32'h0,        1'b1, 5'd4, 1};
`else
    tbl[8] = '{1'b1, 2'd2, 1'b0, 32'h4001, 32'h11223344, 32'h0,        0, 0, 32'h4000, 2'd2, 4'b1111, 32'h11223344, 32'h0,        1'b0, 5'd0, 2};
    tbl[9] = '{1'b0, 2'd1, 1'b1, 32'h5003, 32'h0,        32'hAABBCCDD, 0, 0, 32'h5002, 2'd1, 4'h0,    32'h0,        32'hFFFFAABB, 1'b0, 5'd0, 2};
`endif

    // Reset state
    repeat (3) step();
    chk("rst_ready_busy", 32'({in_ready, busy}), 32'b10);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d_req", 32'(d_req), 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_out_exc", 32'({out_exc, out_exc_code}), 32'd0);
    chk("rst_badvaddr", out_badvaddr, 32'd0);
    chk("rst_bus", 32'({d_wr, d_size, d_wstrb}), 32'd0);
    chk("rst_d_addr", d_addr, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++) do_txn(tbl[i], i);

    // Flush while waiting for data: drained silently, idle the cycle after data_ok
    in_valid = 1'b1; in_write = 1'b0; in_size = 2'd2; in_signed = 1'b0; in_addr = 32'h100;
    step();
    in_valid = 1'b0;
    chk("fd_req", 32'(d_req), 32'd1);
    d_addr_ok = 1'b1;
    step();
    d_addr_ok = 1'b0; in_flush = 1'b1;
    #1;
    chk("fd_data_state", 32'({d_req, out_valid, busy}), 32'b001);
    step();
    in_flush = 1'b0;
    #1;
    chk("fd_drain1", 32'({in_ready, busy, out_valid}), 32'b010);
    step();
    d_data_ok = 1'b1; d_rdata = 32'h55AA55AA;
    #1;
    chk("fd_drain2", 32'({in_ready, out_valid}), 32'b00);
    step();
    d_data_ok = 1'b0;
    #1;
    chk("fd_idle", 32'({in_ready, out_valid}), 32'b10);
    chk("fd_hold_rdata", out_rdata, last_rdata);
    $display("seq flush_in_data: in_ready=%0d out_rdata=%08h", in_ready, out_rdata);

    // Flush before addr_ok: back to idle, request withdrawn
    in_valid = 1'b1; in_addr = 32'h200;
    step();
    in_valid = 1'b0;
    chk("fa_req", 32'(d_req), 32'd1);
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    chk("fa_idle", 32'({d_req, in_ready}), 32'b01);
    step();
    chk("fa_stay_idle", 32'({d_req, busy}), 32'b00);
    $display("seq flush_in_addr: d_req=%0d in_ready=%0d", d_req, in_ready);

    // Flush with a request in idle: dropped
    in_valid = 1'b1; in_flush = 1'b1; in_addr = 32'h240;
    step();
    in_valid = 1'b0; in_flush = 1'b0;
    chk("fi_dropped", 32'({d_req, in_ready}), 32'b01);
    $display("seq flush_in_idle: d_req=%0d in_ready=%0d", d_req, in_ready);

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      rt.wr = 1'($urandom_range(0, 1));
      rt.sz = 2'($urandom_range(0, 3));
      rt.sg = 1'($urandom_range(0, 1));
      rt.addr = 32'($urandom_range(0, 65535));
      rt.wdata = $urandom;
      rt.rdata = $urandom;
      rt.aw = $urandom_range(0, 3);
      rt.dw = $urandom_range(0, 3);
      rt = model(rt);
      do_txn(rt, 100 + i);
    end

    // Flush during the response cycle suppresses out_valid
    in_valid = 1'b1; in_write = 1'b0; in_size = 2'd2; in_addr = 32'h300; in_flush = 1'b0;
    step();
    in_valid = 1'b0;
    d_addr_ok = 1'b1; d_data_ok = 1'b1; d_rdata = 32'h12345678;
    step();
    d_addr_ok = 1'b0; d_data_ok = 1'b0; in_flush = 1'b1;
    #1;
    chk("fr_suppressed", 32'({out_valid, busy}), 32'b01);
    step();
    in_flush = 1'b0;
    #1;
    chk("fr_idle", 32'({in_ready, out_valid}), 32'b10);
    $display("seq flush_in_resp: out_valid=%0d in_ready=%0d", out_valid, in_ready);

    // Reset while requesting
    in_valid = 1'b1; in_write = 1'b1; in_size = 2'd0; in_addr = 32'h401; in_wdata = 32'hFF;
    step();
    in_valid = 1'b0;
    chk("ra_req", 32'(d_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ra_req_drop", 32'({d_req, in_ready, busy}), 32'b010);
    chk("ra_bus_zero", 32'({d_wr, d_size, d_wstrb}), 32'd0);
    chk("ra_addr_zero", d_addr, 32'd0);
    chk("ra_wdata_zero", d_wdata, 32'd0);
    chk("ra_out_zero", 32'({out_valid, out_exc}), 32'd0);
    chk("ra_rdata_zero", out_rdata, 32'd0);
    $display("seq reset_in_addr: d_req=%0d in_ready=%0d", d_req, in_ready);

    do_txn(tbl[0], 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
